// File: rtl/mode_scheduler_if.sv
// Scheduler <-> environment signal bundle: mode flags and frame sync in, pipeline control out.
// master is the scheduler side, slave is the requester/pipeline side.
interface mode_scheduler_if;
    logic [7:0] mode_req;
    logic       vs_in;
    logic       pipe_idle;
    logic [2:0] mode_sel;
    logic [7:0] mode_onehot;
    logic       mode_valid;
    logic       cfg_load;
    logic       pipe_stop;
    logic       timeout_err;

    modport master (
        input  mode_req, vs_in, pipe_idle,
        output mode_sel, mode_onehot, mode_valid, cfg_load, pipe_stop, timeout_err
    );

    modport slave (
        output mode_req, vs_in, pipe_idle,
        input  mode_sel, mode_onehot, mode_valid, cfg_load, pipe_stop, timeout_err
    );
endinterface

// File: rtl/mode_scheduler.sv
// Round-robin scheduler sharing one video pipeline among 8 mode requests.
// Switches only on frame starts, draining the pipeline with a stop/idle handshake first.
module mode_scheduler #(
    parameter int unsigned FRAMES_PER_MODE = 60,
    parameter int unsigned ACK_TIMEOUT     = 1024
) (
    input logic              clk,
    input logic              rst_n,
    mode_scheduler_if.master bus
);
    localparam int unsigned FW = $clog2(FRAMES_PER_MODE) + 1;
    localparam int unsigned TW = $clog2(ACK_TIMEOUT) + 1;
    localparam logic [FW-1:0] FCNT_LAST = FW'(FRAMES_PER_MODE - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(ACK_TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_WAIT_FS = 3'd2;
    localparam logic [2:0] ST_RUN     = 3'd3;
    localparam logic [2:0] ST_STOP    = 3'd4;

    logic [2:0]    state_q, state_d;
    logic          vs_d1_q;
    logic [2:0]    cur_q, cur_d;
    logic [2:0]    nxt_q, nxt_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [2:0]    mode_sel_q, mode_sel_d;
    logic [7:0]    mode_onehot_q, mode_onehot_d;
    logic          mode_valid_q, mode_valid_d;
    logic          cfg_load_q, cfg_load_d;
    logic          pipe_stop_q, pipe_stop_d;
    logic          timeout_err_q, timeout_err_d;

    logic       fs;
    logic [2:0] rr_pick;
    logic       others_req;

    assign fs         = bus.vs_in & ~vs_d1_q;
    assign others_req = (bus.mode_req & ~(8'd1 << cur_q)) != 8'd0;

    // First set request strictly after cur_q, wrapping; cur_q itself is checked last.
    always_comb begin
        logic       found;
        logic [2:0] idx;
        rr_pick = cur_q;
        found   = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = cur_q + 3'(i);
            if (!found && bus.mode_req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        nxt_d         = nxt_q;
        frame_cnt_d   = frame_cnt_q;
        to_cnt_d      = to_cnt_q;
        mode_sel_d    = mode_sel_q;
        mode_onehot_d = mode_onehot_q;
        mode_valid_d  = mode_valid_q;
        cfg_load_d    = 1'b0;
        pipe_stop_d   = pipe_stop_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                mode_valid_d  = 1'b0;
                mode_onehot_d = 8'd0;
                pipe_stop_d   = 1'b0;
                if (bus.mode_req != 8'd0) state_d = ST_SELECT;
            end
            ST_SELECT: begin
                if (bus.mode_req == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    nxt_d   = rr_pick;
                    state_d = ST_WAIT_FS;
                end
            end
            ST_WAIT_FS: begin
                if (!bus.mode_req[nxt_q]) begin
                    state_d = ST_SELECT;
                end else if (fs) begin
                    cur_d         = nxt_q;
                    mode_sel_d    = nxt_q;
                    mode_onehot_d = 8'd1 << nxt_q;
                    mode_valid_d  = 1'b1;
                    cfg_load_d    = 1'b1;
                    frame_cnt_d   = '0;
                    state_d       = ST_RUN;
                end
            end
            ST_RUN: begin
                // A dropped request wins over a coincident frame start.
                if (!bus.mode_req[cur_q] || (fs && frame_cnt_q == FCNT_LAST && others_req)) begin
                    pipe_stop_d   = 1'b1;
                    mode_valid_d  = 1'b0;
                    mode_onehot_d = 8'd0;
                    to_cnt_d      = '0;
                    state_d       = ST_STOP;
                end else if (fs && frame_cnt_q != FCNT_LAST) begin
                    frame_cnt_d = frame_cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (bus.pipe_idle || to_cnt_q == TCNT_LAST) begin
                    if (!bus.pipe_idle) timeout_err_d = 1'b1;
                    pipe_stop_d = 1'b0;
                    to_cnt_d    = '0;
                    state_d     = (bus.mode_req != 8'd0) ? ST_SELECT : ST_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            vs_d1_q       <= 1'b0;
            cur_q         <= 3'd7;
            nxt_q         <= 3'd0;
            frame_cnt_q   <= '0;
            to_cnt_q      <= '0;
            mode_sel_q    <= 3'd0;
            mode_onehot_q <= 8'd0;
            mode_valid_q  <= 1'b0;
            cfg_load_q    <= 1'b0;
            pipe_stop_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            vs_d1_q       <= bus.vs_in;
            cur_q         <= cur_d;
            nxt_q         <= nxt_d;
            frame_cnt_q   <= frame_cnt_d;
            to_cnt_q      <= to_cnt_d;
            mode_sel_q    <= mode_sel_d;
            mode_onehot_q <= mode_onehot_d;
            mode_valid_q  <= mode_valid_d;
            cfg_load_q    <= cfg_load_d;
            pipe_stop_q   <= pipe_stop_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.mode_sel    = mode_sel_q;
    assign bus.mode_onehot = mode_onehot_q;
    assign bus.mode_valid  = mode_valid_q;
    assign bus.cfg_load    = cfg_load_q;
    assign bus.pipe_stop   = pipe_stop_q;
    assign bus.timeout_err = timeout_err_q;
endmodule
